// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// Widths here are the default sizes of the register-file datapath.
package regfile_pkg;

    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_COUNT  = 32;

    typedef enum logic {
        PRIO_ALU,
        PRIO_LSU
    } wb_prio_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/reg_hazard_cmp.sv
// Compares one read address against the three pending-write sources.
// Register x0 is hardwired to zero, so it never has a hazard.
module reg_hazard_cmp #(
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] i_rs_addr,
    input  logic                  i_dest_en,
    input  logic [ADDR_WIDTH-1:0] i_dest_addr,
    input  logic                  i_alu_valid,
    input  logic [ADDR_WIDTH-1:0] i_alu_addr,
    input  logic                  i_lsu_valid,
    input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
    output logic                  o_hit
);
    import regfile_pkg::*;

    logic w_dest_hit;
    logic w_alu_hit;
    logic w_lsu_hit;

    assign w_dest_hit = i_dest_en   && (i_dest_addr == i_rs_addr);
    assign w_alu_hit  = i_alu_valid && (i_alu_addr  == i_rs_addr);
    assign w_lsu_hit  = i_lsu_valid && (i_lsu_addr  == i_rs_addr);

    assign o_hit = (i_rs_addr != '0) && (w_dest_hit || w_alu_hit || w_lsu_hit);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between ALU and LSU.
// ALU has fixed priority; the LSU is forced through after STARVE_LIMIT blocked cycles.
module regfile_wb_arbiter #(
    parameter int WIDTH        = regfile_pkg::WIDTH,
    parameter int ADDR_WIDTH   = regfile_pkg::ADDR_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [WIDTH-1:0]      lsu_data,
    output logic                  dest_en,
    output logic [ADDR_WIDTH-1:0] dest_addr,
    output logic [WIDTH-1:0]      dest_data,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_hazard,
    output logic                  rs2_hazard
);
    import regfile_pkg::*;

    localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

    wb_prio_e              r_state;
    wb_prio_e              w_state_nxt;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic [CNT_W-1:0]      w_starve_nxt;
    logic                  w_alu_fire;
    logic                  w_lsu_fire;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [WIDTH-1:0]      w_sel_data;
    logic                  r_dest_en;
    logic [ADDR_WIDTH-1:0] r_dest_addr;
    logic [WIDTH-1:0]      r_dest_data;
    logic                  w_rs1_hit;
    logic                  w_rs2_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PRIO_ALU;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // PRIO_LSU always lasts exactly one cycle: it either grants the LSU or finds it idle.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            PRIO_ALU: begin
                if (lsu_valid && !lsu_ready) begin
                    w_starve_nxt = r_starve_cnt + CNT_W'(1);
                    if ((STARVE_LIMIT != 0) && (w_starve_nxt == CNT_W'(STARVE_LIMIT))) begin
                        w_state_nxt = PRIO_LSU;
                    end
                end else begin
                    w_starve_nxt = '0;
                end
            end
            PRIO_LSU: begin
                w_state_nxt  = PRIO_ALU;
                w_starve_nxt = '0;
            end
            default: begin
                w_state_nxt  = PRIO_ALU;
                w_starve_nxt = '0;
            end
        endcase
    end

    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                PRIO_ALU: begin
                    alu_ready = 1'b1;
                    lsu_ready = !alu_valid;
                end
                PRIO_LSU: begin
                    lsu_ready = 1'b1;
                    alu_ready = !lsu_valid;
                end
                default: begin
                    alu_ready = 1'b0;
                    lsu_ready = 1'b0;
                end
            endcase
        end
    end

    assign w_alu_fire = alu_valid && alu_ready;
    assign w_lsu_fire = lsu_valid && lsu_ready;
    assign w_sel_addr = w_alu_fire ? alu_addr : lsu_addr;
    assign w_sel_data = w_alu_fire ? alu_data : lsu_data;

    // x0 requests still load addr/data but leave the write enable low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dest_en   <= 1'b0;
            r_dest_addr <= '0;
            r_dest_data <= '0;
        end else if (w_alu_fire || w_lsu_fire) begin
            r_dest_en   <= (w_sel_addr != '0);
            r_dest_addr <= w_sel_addr;
            r_dest_data <= w_sel_data;
        end else begin
            r_dest_en   <= 1'b0;
        end
    end

    assign dest_en   = r_dest_en;
    assign dest_addr = r_dest_addr;
    assign dest_data = r_dest_data;

    reg_hazard_cmp #(.ADDR_WIDTH(ADDR_WIDTH)) u_rs1_cmp (
        .i_rs_addr   (rs1_addr),
        .i_dest_en   (r_dest_en),
        .i_dest_addr (r_dest_addr),
        .i_alu_valid (alu_valid),
        .i_alu_addr  (alu_addr),
        .i_lsu_valid (lsu_valid),
        .i_lsu_addr  (lsu_addr),
        .o_hit       (w_rs1_hit)
    );

    reg_hazard_cmp #(.ADDR_WIDTH(ADDR_WIDTH)) u_rs2_cmp (
        .i_rs_addr   (rs2_addr),
        .i_dest_en   (r_dest_en),
        .i_dest_addr (r_dest_addr),
        .i_alu_valid (alu_valid),
        .i_alu_addr  (alu_addr),
        .i_lsu_valid (lsu_valid),
        .i_lsu_addr  (lsu_addr),
        .o_hit       (w_rs2_hit)
    );

    assign rs1_hazard = w_rs1_hit && !rst;
    assign rs2_hazard = w_rs2_hit && !rst;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: instance 0 uses STARVE_LIMIT=4, instance 1 uses STARVE_LIMIT=0.
// Both are checked every cycle against a behavioural arbitration model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          av [2];
    logic          ar [2];
    logic [AW-1:0] aa [2];
    logic [DW-1:0] ad [2];
    logic          lv [2];
    logic          lr [2];
    logic [AW-1:0] la [2];
    logic [DW-1:0] ld [2];
    logic          de [2];
    logic [AW-1:0] dad[2];
    logic [DW-1:0] dd [2];
    logic          h1 [2];
    logic          h2 [2];
    logic [AW-1:0] rs1, rs2;

    regfile_wb_arbiter #(.WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut0 (
        .clk(clk), .rst(rst),
        .alu_valid(av[0]), .alu_ready(ar[0]), .alu_addr(aa[0]), .alu_data(ad[0]),
        .lsu_valid(lv[0]), .lsu_ready(lr[0]), .lsu_addr(la[0]), .lsu_data(ld[0]),
        .dest_en(de[0]), .dest_addr(dad[0]), .dest_data(dd[0]),
        .rs1_addr(rs1), .rs2_addr(rs2), .rs1_hazard(h1[0]), .rs2_hazard(h2[0])
    );

    regfile_wb_arbiter #(.WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(0)) dut1 (
        .clk(clk), .rst(rst),
        .alu_valid(av[1]), .alu_ready(ar[1]), .alu_addr(aa[1]), .alu_data(ad[1]),
        .lsu_valid(lv[1]), .lsu_ready(lr[1]), .lsu_addr(la[1]), .lsu_data(ld[1]),
        .dest_en(de[1]), .dest_addr(dad[1]), .dest_data(dd[1]),
        .rs1_addr(rs1), .rs2_addr(rs2), .rs1_hazard(h1[1]), .rs2_hazard(h2[1])
    );

    int checks = 0;
    int failures = 0;

    // Model: count consecutive cycles the LSU waited; once the limit is hit it gets one forced slot.
    int      lim[2] = '{4, 0};
    int      blocked[2];
    bit      forced[2];
    bit      e_en[2];
    wb_req_t e_req[2];

    // Grants and hazards as observed from the DUTs in the most recent cycle.
    bit g_a[2];
    bit g_l[2];
    bit c_h1[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_haz(input int k, input logic [AW-1:0] rs);
        return (rs != '0) && ((e_en[k] && e_req[k].addr == rs) ||
                              (av[k] && aa[k] == rs) || (lv[k] && la[k] == rs));
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            blocked[k] = 0;
            forced[k]  = 1'b0;
            e_en[k]    = 1'b0;
            e_req[k]   = '0;
        end
    endtask

    // Checks all outputs at the negedge, advances the model, returns at posedge+1.
    task automatic cycle();
        bit xa, xl, fa, fl;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            xa = forced[k] ? !lv[k] : 1'b1;
            xl = forced[k] ? 1'b1 : !av[k];
            check($sformatf("alu_ready%0d", k), ar[k], xa);
            check($sformatf("lsu_ready%0d", k), lr[k], xl);
            check($sformatf("dest_en%0d", k), de[k], e_en[k]);
            check($sformatf("dest_addr%0d", k), dad[k], e_req[k].addr);
            check($sformatf("dest_data%0d", k), dd[k], e_req[k].data);
            check($sformatf("rs1_hazard%0d", k), h1[k], exp_haz(k, rs1));
            check($sformatf("rs2_hazard%0d", k), h2[k], exp_haz(k, rs2));
            g_a[k]  = av[k] && ar[k];
            g_l[k]  = lv[k] && lr[k];
            c_h1[k] = h1[k];
            fa = av[k] && xa;
            fl = lv[k] && xl;
            if (forced[k]) begin
                forced[k]  = 1'b0;
                blocked[k] = 0;
            end else if (lv[k] && !xl) begin
                blocked[k]++;
                if (lim[k] != 0 && blocked[k] == lim[k]) forced[k] = 1'b1;
            end else begin
                blocked[k] = 0;
            end
            if (fa || fl) begin
                e_req[k] = fa ? {aa[k], ad[k]} : {la[k], ld[k]};
                e_en[k]  = (e_req[k].addr != '0);
            end else begin
                e_en[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit a_v, input logic [AW-1:0] a_a, input logic [DW-1:0] a_d,
                         input bit l_v, input logic [AW-1:0] l_a, input logic [DW-1:0] l_d);
        for (int k = 0; k < 2; k++) begin
            av[k] = a_v; aa[k] = a_a; ad[k] = a_d;
            lv[k] = l_v; la[k] = l_a; ld[k] = l_d;
        end
    endtask

    initial begin
        rst = 1'b1;
        rs1 = 5'd3;
        rs2 = 5'd4;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_alu_ready%0d", k), ar[k], 1'b0);
            check($sformatf("rst_lsu_ready%0d", k), lr[k], 1'b0);
            check($sformatf("rst_dest_en%0d", k), de[k], 1'b0);
            check($sformatf("rst_hazard1_%0d", k), h1[k], 1'b0);
            check($sformatf("rst_hazard2_%0d", k), h2[k], 1'b0);
        end

        // Release; a lone ALU request is accepted in the first cycle.
        rst = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 32'h0);
        cycle();
        check("first_alu_grant", g_a[0], 1'b1);

        // Single write to x5.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("single_en", de[0], 1'b1);
        check("single_addr", dad[0], 5'd5);
        check("single_data", dd[0], 32'hDEADBEEF);
        cycle();
        check("single_en_drop", de[0], 1'b0);

        // Reset in the middle of a write clears the output register immediately.
        drive(1'b1, 5'd9, 32'hCAFE0009, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("midwrite_en", de[0], 1'b1);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("async_rst_en%0d", k), de[k], 1'b0);
            check($sformatf("async_rst_addr%0d", k), dad[k], 5'd0);
            check($sformatf("async_rst_data%0d", k), dd[k], 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();

        // Continuous contention: instance 0 rotates 4:1, instance 1 never grants the LSU.
        rs1 = 5'd0;
        rs2 = 5'd0;
        drive(1'b1, 5'd1, 32'hA1A1A1A1, 1'b1, 5'd2, 32'hB2B2B2B2);
        for (int i = 0; i < 20; i++) begin
            cycle();
            check($sformatf("contend_lim4_c%0d", i), {g_a[0], g_l[0]}, (i % 5 == 4) ? 2'b01 : 2'b10);
            check($sformatf("contend_lim0_c%0d", i), {g_a[1], g_l[1]}, 2'b10);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hB2B2B2B2);
        cycle();
        check("lim0_lsu_on_alu_drop", g_l[1], 1'b1);

        // x0 write from the LSU is accepted but never enabled.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678);
        cycle();
        check("x0_lsu_grant", g_l[0], 1'b1);
        check("x0_hazard_req", c_h1[0], 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("x0_dest_en", de[0], 1'b0);
        check("x0_hazard_out", h1[0], 1'b0);
        cycle();

        // Hazard window for an ALU write to x7.
        rs1 = 5'd7;
        rs2 = 5'd8;
        drive(1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, 32'h0);
        cycle();
        check("haz_req_rs1", c_h1[0], 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("haz_out_rs1", h1[0], 1'b1);
        check("haz_out_rs2", h2[0], 1'b0);
        cycle();
        check("haz_after_rs1", h1[0], 1'b0);

        // Random traffic; each requester holds its request until its own DUT accepts it.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!av[k] || g_a[k]) begin
                    av[k] = ($urandom_range(0, 2) != 0);
                    aa[k] = AW'($urandom_range(0, 31));
                    ad[k] = $urandom;
                end
                if (!lv[k] || g_l[k]) begin
                    lv[k] = ($urandom_range(0, 2) != 0);
                    la[k] = AW'($urandom_range(0, 31));
                    ld[k] = $urandom;
                end
            end
            rs1 = AW'($urandom_range(0, 31));
            rs2 = AW'($urandom_range(0, 31));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (dest_en/dest_addr/dest_data) between two writeback requesters: the ALU and the load/store unit (LSU).
- Each requester uses a valid/ready handshake.
- The ALU has fixed priority, with a starvation guard for the LSU.
- Granted writes pass through a one-cycle output register that drives the register file directly.
- Combinational hazard flags report any in-flight write to the two read addresses; the issue logic uses them to stall.

Parameters:
- WIDTH, 32, data width.
- ADDR_WIDTH, 5, register address width (32 registers).
- STARVE_LIMIT, 4, consecutive LSU-blocked cycles before the LSU is forced priority; 0 disables the guard (pure fixed priority).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU write request
- alu_ready  output  1  ALU request accepted this cycle
- alu_addr  input  ADDR_WIDTH  ALU destination register
- alu_data  input  WIDTH  ALU write data
- lsu_valid  input  1  LSU write request
- lsu_ready  output  1  LSU request accepted this cycle
- lsu_addr  input  ADDR_WIDTH  LSU destination register
- lsu_data  input  WIDTH  LSU write data
- dest_en  output  1  register file write enable
- dest_addr  output  ADDR_WIDTH  register file write address
- dest_data  output  WIDTH  register file write data
- rs1_addr  input  ADDR_WIDTH  read port 1 address under query
- rs2_addr  input  ADDR_WIDTH  read port 2 address under query
- rs1_hazard  output  1  pending write to rs1_addr
- rs2_hazard  output  1  pending write to rs2_addr

Behaviour:
- Reset (async, immediate):
  - dest_en=0, dest_addr=0, dest_data=0.
  - State=PRIO_ALU, starve_cnt=0.
  - alu_ready=lsu_ready=0 while rst is high.
- Handshake:
  - A transfer occurs on a rising edge when valid&&ready.
  - Requesters hold valid, addr and data stable until accepted; valid must not depend on ready.
  - ready may depend on the other requester's valid (combinational).
  - The output stage never back-pressures.
- FSM states:
  - PRIO_ALU:
    - alu_ready=1.
    - lsu_ready = !alu_valid.
    - If lsu_valid && !lsu_ready, starve_cnt++ at the edge.
    - Otherwise starve_cnt=0.
    - When starve_cnt reaches STARVE_LIMIT (and STARVE_LIMIT≠0), go to PRIO_LSU next cycle.
  - PRIO_LSU:
    - lsu_ready=1.
    - alu_ready = !lsu_valid.
    - After one LSU transfer, return to PRIO_ALU with starve_cnt=0.
    - If lsu_valid=0 in this state (protocol violation), return to PRIO_ALU and clear starve_cnt, with no grant change that cycle.
- Latency:
  - A transfer at edge N loads the output register, so dest_* are valid during cycle N+1.
  - The register file commits at edge N+1.
  - With no new transfer at edge N+1, dest_en returns to 0.
  - dest_addr/dest_data update only on a transfer.
- x0 writes:
  - A request with addr=0 is handshaken normally.
  - The output register keeps dest_en=0 (write discarded).
  - An x0 request still consumes its grant slot and counts for starvation and state transitions.
- Simultaneous requests: exactly one grant per cycle; never both readies with both valids.
- Hazard flags (combinational), for each port k:
  - rsk_hazard = (rsk_addr≠0) && ((dest_en && dest_addr==rsk_addr) || (alu_valid && alu_addr==rsk_addr) || (lsu_valid && lsu_addr==rsk_addr)).
  - Flags are forced to 0 during reset.
- Same-address back-to-back writes: committed in grant order, with no merging.

Decomposition:
- Package regfile_pkg holds:
  - WIDTH, ADDR_WIDTH and REG_COUNT=32 constants.
  - Enum wb_prio_e {PRIO_ALU, PRIO_LSU}.
  - Typedef wb_req_t {addr, data}.
- Sub-module reg_hazard_cmp (one address vs. three pending-write sources) is instantiated twice, for rs1 and rs2.
- Everything else stays in one module.

Test Plan:
1. Reset: assert rst mid-write (dest_en=1) -> dest_en=0, dest_addr=0, dest_data=0 immediately; after release, alu_valid alone gets alu_ready=1 on the first cycle.
2. Single write: alu_valid, addr=5, data=0xDEADBEEF at edge N -> dest_en=1, dest_addr=5, dest_data=0xDEADBEEF in cycle N+1; dest_en=0 in cycle N+2.
3. Contention, STARVE_LIMIT=4, both valid continuously with distinct addrs -> grant sequence ALU,ALU,ALU,ALU,LSU, repeating; never both readies high.
4. x0: lsu_valid, addr=0, data=0x12345678 -> lsu_ready=1, dest_en stays 0; rs1_addr=0 -> rs1_hazard=0 throughout.
5. Hazard window: alu_valid addr=7 with rs1_addr=7, rs2_addr=8 -> rs1_hazard=1, rs2_hazard=0 in the request cycle and the output cycle; rs1_hazard=0 in the cycle after.
6. STARVE_LIMIT=0, both valid for 20 cycles -> LSU never granted; the LSU is granted in the first cycle alu_valid drops.
